in_data_packer: RTL and testbench

Upstream feeder stage for the 96-bit `in_data` compute blocks. It accepts a byte stream over a valid/ready handshake and packs 12 bytes, little-endian, into one 96-bit word. It presents each word on a valid/ready output port that drives the downstream `in_data` bus. Frames may end early via `byte_last`; a short word is zero-padded and flagged partial.

---
 rtl/in_data_packer.sv | 134 +++++++++++++
 tb/tb_in_data_packer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/in_data_packer.sv
// Byte-to-word packer: collects BYTES_PER_WORD bytes little-endian into one word,
// with one closed word of skid buffering. Optional per-lane parity via PACKER_PARITY_EN.
module in_data_packer #(
    parameter int BYTES_PER_WORD = 12
) (
    input  logic [159:0]                  clkin_data,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    input  logic                          byte_last,
    output logic                          byte_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [8*BYTES_PER_WORD-1:0]   out_data,
    output logic [4:0]                    out_count,
    output logic                          out_partial,
    output logic [15:0]                   word_cnt
`ifdef PACKER_PARITY_EN
    ,
    output logic [BYTES_PER_WORD-1:0]     out_parity
`endif
);

    localparam int         W     = 8 * BYTES_PER_WORD;
    localparam logic [4:0] BPW_C = 5'(BYTES_PER_WORD);

    logic clk;
    logic rst;
    logic unused_clkin;

    assign clk          = clkin_data[0];
    assign rst          = clkin_data[32];
    assign unused_clkin = ^{clkin_data[159:33], clkin_data[31:1]};

    // Assembly register A and the pending flag
    logic [W-1:0] abuf;
    logic [4:0]   acnt;
    logic         pend;

    logic         in_fire;
    logic         out_fire;
    logic         o_free;
    logic [W-1:0] merged;
    logic [4:0]   next_cnt;
    logic         closing;
    logic         o_load;
    logic [W-1:0] o_src_data;
    logic [4:0]   o_src_cnt;

    assign byte_ready = !rst && !pend;
    assign in_fire    = byte_valid && byte_ready;
    assign out_fire   = out_valid && out_ready;
    assign o_free     = !out_valid || out_ready;
    assign next_cnt   = acnt + 5'd1;
    assign closing    = in_fire && (byte_last || (next_cnt == BPW_C));

    // NOTE: every always_comb output gets a default before any conditional write,
    // otherwise the tool infers a latch to hold the old value.
    always_comb begin
        merged = abuf;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (acnt == 5'(i)) begin
                merged[8*i +: 8] = byte_data;
            end
        end
    end

    // O loads either from the draining pending word or straight from the closing byte
    assign o_load     = pend ? out_fire : (closing && o_free);
    assign o_src_data = pend ? abuf : merged;
    assign o_src_cnt  = pend ? acnt : next_cnt;

    // NOTE: state registers use non-blocking assignments so every process sees
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: abuf is reset (unlike a plain data buffer) because zero padding
            // of short words relies on lanes above acnt being clean.
            abuf        <= '0;
            acnt        <= '0;
            pend        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_count   <= '0;
            out_partial <= 1'b0;
            word_cnt    <= '0;
        end else begin
            if (out_fire) begin
                word_cnt <= word_cnt + 16'd1;
            end

            if (o_load) begin
                out_valid   <= 1'b1;
                out_data    <= o_src_data;
                out_count   <= o_src_cnt;
                out_partial <= (o_src_cnt < BPW_C);
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            if (o_load) begin
                abuf <= '0;
                acnt <= '0;
                pend <= 1'b0;
            end else if (in_fire) begin
                abuf <= merged;
                acnt <= next_cnt;
                if (closing) begin
                    pend <= 1'b1;
                end
            end
        end
    end

`ifdef PACKER_PARITY_EN
    function automatic logic [BYTES_PER_WORD-1:0] lane_parity(input logic [W-1:0] word);
        logic [BYTES_PER_WORD-1:0] p;
        p = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            p[i] = ^word[8*i +: 8];
        end
        return p;
    endfunction

    // Padded lanes are zero, so their parity bit is naturally 0
    always_ff @(posedge clk) begin
        if (rst) begin
            out_parity <= '0;
        end else if (o_load) begin
            out_parity <= lane_parity(o_src_data);
        end
    end
`endif

endmodule

// File: tb/tb_in_data_packer.sv
// Directed bench for in_data_packer: table of frames plus hand-written
// backpressure, simultaneous close/drain and reset sequences.
module tb_in_data_packer;

    localparam int BPW = 12;
    localparam int W   = 8 * BPW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [159:0]  clkin_data;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data  = 8'h00;
    logic          byte_last  = 1'b0;
    logic          byte_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [4:0]    out_count;
    logic          out_partial;
    logic [15:0]   word_cnt;
`ifdef PACKER_PARITY_EN
    logic [BPW-1:0] out_parity;
`endif

    // Ignored bus bits carry junk so the design must not depend on them
    assign clkin_data = {127'(32'hDEADBEEF), rst, 31'h2AAA_5555, clk};

    always #5 clk = ~clk;

    in_data_packer #(.BYTES_PER_WORD(BPW)) dut (
        .clkin_data  (clkin_data),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count),
        .out_partial (out_partial),
        .word_cnt    (word_cnt)
`ifdef PACKER_PARITY_EN
        ,
        .out_parity  (out_parity)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        tick();
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    typedef struct {
        int          n;
        logic [7:0]  start;
        logic        last;
        logic [95:0] exp_data;
        logic [4:0]  exp_count;
        logic        exp_partial;
    } vec_t;

    vec_t        vecs[5];
    logic [15:0] exp_wc;

    initial begin
        int          accepted;
        int          idx;
        logic        stable_bad;
        logic        drop_checked;
        logic        ready_bad;
        logic [95:0] w1;
        logic [95:0] w2;

        vecs[0] = '{12, 8'h01, 1'b0, 96'h0C0B0A09_08070605_04030201, 5'd12, 1'b0};
        vecs[1] = '{5,  8'h11, 1'b1, 96'h00000000_00000015_14131211, 5'd5,  1'b1};
        vecs[2] = '{1,  8'h5A, 1'b1, 96'h00000000_00000000_0000005A, 5'd1,  1'b1};
        vecs[3] = '{12, 8'h30, 1'b1, 96'h3B3A3938_37363534_33323130, 5'd12, 1'b0};
        vecs[4] = '{11, 8'hF0, 1'b1, 96'h00FAF9F8_F7F6F5F4_F3F2F1F0, 5'd11, 1'b1};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_byte_ready", byte_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_partial", out_partial, 0);
        check("rst_word_cnt", word_cnt, 0);
        rst    = 1'b0;
        exp_wc = 16'd0;
        #1;
        check("post_rst_byte_ready", byte_ready, 1);

        // Table of single frames, out_ready held high
        out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            ready_bad = 1'b0;
            for (int k = 0; k < vecs[v].n; k++) begin
                if (!byte_ready) ready_bad = 1'b1;
                send_byte(vecs[v].start + 8'(k), vecs[v].last && (k == vecs[v].n - 1));
            end
            check($sformatf("vec%0d_ready", v), ready_bad, 0);
            check($sformatf("vec%0d_valid", v), out_valid, 1);
            check($sformatf("vec%0d_data", v), out_data, vecs[v].exp_data);
            check($sformatf("vec%0d_count", v), out_count, vecs[v].exp_count);
            check($sformatf("vec%0d_partial", v), out_partial, vecs[v].exp_partial);
            check($sformatf("vec%0d_wc_before", v), word_cnt, exp_wc);
            tick();
            exp_wc++;
            check($sformatf("vec%0d_valid_after", v), out_valid, 0);
            check($sformatf("vec%0d_wc_after", v), word_cnt, exp_wc);
        end

        // Back-to-back words: no bubble, next byte goes to lane 0
        ready_bad = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (!byte_ready) ready_bad = 1'b1;
            send_byte(8'h80 + 8'(k), 1'b0);
            if (k == 11) check("b2b_word_a", out_data, 96'h8B8A8988_87868584_83828180);
            if (k == 12) exp_wc++;
        end
        check("b2b_no_bubble", ready_bad, 0);
        check("b2b_valid", out_valid, 1);
        check("b2b_word_b", out_data, 96'h97969594_93929190_8F8E8D8C);
        check("b2b_wc", word_cnt, exp_wc);
        tick();
        exp_wc++;
        check("b2b_drained", out_valid, 0);

        // Backpressure: 30 bytes offered, only 24 fit
        out_ready    = 1'b0;
        accepted     = 0;
        idx          = 0;
        stable_bad   = 1'b0;
        drop_checked = 1'b0;
        w1 = 96'h4B4A4948_47464544_43424140;
        w2 = 96'h57565554_53525150_4F4E4D4C;
        for (int c = 0; c < 40; c++) begin
            byte_valid = (idx < 30);
            byte_data  = 8'h40 + 8'(idx);
            byte_last  = 1'b0;
            if (byte_valid && byte_ready) begin
                accepted++;
                idx++;
            end
            tick();
            if (out_valid && (out_data !== w1)) stable_bad = 1'b1;
            if (accepted == 24 && !drop_checked) begin
                check("bp_ready_drop", byte_ready, 0);
                drop_checked = 1'b1;
            end
        end
        byte_valid = 1'b0;
        check("bp_accepted", accepted, 24);
        check("bp_ready_low", byte_ready, 0);
        check("bp_stable", stable_bad, 0);
        check("bp_word1", out_data, w1);
        check("bp_count1", out_count, 12);
        out_ready = 1'b1;
        tick();
        exp_wc++;
        check("bp_word2_valid", out_valid, 1);
        check("bp_word2", out_data, w2);
        check("bp_ready_back", byte_ready, 1);
        check("bp_wc", word_cnt, exp_wc);
        tick();
        exp_wc++;
        check("bp_drained", out_valid, 0);

        // Closing byte of word 2 on the same edge as the word-1 transfer
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) send_byte(8'h60 + 8'(k), 1'b0);
        check("sim_word1", out_data, 96'h6B6A6968_67666564_63626160);
        ready_bad = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (!byte_ready) ready_bad = 1'b1;
            send_byte(8'h70 + 8'(k), 1'b0);
        end
        if (!byte_ready) ready_bad = 1'b1;
        out_ready = 1'b1;
        send_byte(8'h7B, 1'b0);
        exp_wc++;
        check("sim_never_pend", ready_bad | !byte_ready, 0);
        check("sim_valid", out_valid, 1);
        check("sim_word2", out_data, 96'h7B7A7978_77767574_73727170);
        check("sim_count", out_count, 12);
        check("sim_wc", word_cnt, exp_wc);
        tick();
        exp_wc++;
        check("sim_drained", out_valid, 0);

        // Reset mid-word with a word held in O
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) send_byte(8'hC0 + 8'(k), 1'b0);
        for (int k = 0; k < 7; k++) send_byte(8'hD0 + 8'(k), 1'b0);
        rst = 1'b1;
        tick();
        check("mid_rst_ready", byte_ready, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_count", out_count, 0);
        check("mid_rst_partial", out_partial, 0);
        check("mid_rst_wc", word_cnt, 0);
        rst       = 1'b0;
        exp_wc    = 16'd0;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) send_byte(8'hA0 + 8'(k), 1'b0);
        check("mid_clean_valid", out_valid, 1);
        check("mid_clean_data", out_data, 96'hABAAA9A8_A7A6A5A4_A3A2A1A0);
        check("mid_clean_count", out_count, 12);
        check("mid_clean_partial", out_partial, 0);
        tick();
        exp_wc++;
        check("mid_clean_wc", word_cnt, exp_wc);

`ifdef PACKER_PARITY_EN
        send_byte(8'h07, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int k = 0; k < 10; k++) send_byte(8'h00, 1'b0);
        check("parity", out_parity, 12'h001);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
